// File: rtl/gnn_node_if.sv
// Handshake and data bundle for gnn_node_engine: graph/weight load port, per-node result stream
// and status.
interface gnn_node_if #(
   parameter int unsigned N_NODES = 4,
   parameter int unsigned N_FEAT  = 4,
   parameter int unsigned N_HID   = 4,
   parameter int unsigned N_OUT   = 2,
   parameter int unsigned IN_W    = 5,
   parameter int unsigned W_W     = 5
) ();
   localparam int unsigned AGG_W = IN_W + $clog2(N_NODES);
   localparam int unsigned HID_W = AGG_W + W_W + $clog2(N_FEAT);
   localparam int unsigned OUT_W = HID_W + W_W + $clog2(N_HID);

   logic                              in_valid;
   logic                              in_ready;
   logic [N_NODES*N_FEAT*IN_W-1:0]    x_flat;
   logic [N_NODES*N_NODES-1:0]        adj;
   logic [N_FEAT*N_HID*W_W-1:0]       w1_flat;
   logic [N_HID*N_OUT*W_W-1:0]        w2_flat;
   logic                              out_valid;
   logic                              out_ready;
   logic [$clog2(N_NODES)-1:0]        out_node;
   logic                              out_last;
   logic [N_OUT*OUT_W-1:0]            out_data;
   logic                              busy;

   modport slave (
      input  in_valid, x_flat, adj, w1_flat, w2_flat, out_ready,
      output in_ready, out_valid, out_node, out_last, out_data, busy
   );

   modport master (
      output in_valid, x_flat, adj, w1_flat, w2_flat, out_ready,
      input  in_ready, out_valid, out_node, out_last, out_data, busy
   );
endinterface

// File: rtl/gnn_node_engine.sv
// Time-multiplexed GNN node engine: per node, aggregate neighbour features over the adjacency
// mask, then run a two-layer unsigned MAC and stream one result vector per node.
module gnn_node_engine #(
   parameter int unsigned N_NODES  = 4,
   parameter int unsigned N_FEAT   = 4,
   parameter int unsigned N_HID    = 4,
   parameter int unsigned N_OUT    = 2,
   parameter int unsigned IN_W     = 5,
   parameter int unsigned W_W      = 5,
   parameter int unsigned AGG_MODE = 0
) (
   input logic        clk,
   input logic        rst,
   gnn_node_if.slave  bus
);
   localparam int unsigned AGG_W    = IN_W + $clog2(N_NODES);
   localparam int unsigned HID_W    = AGG_W + W_W + $clog2(N_FEAT);
   localparam int unsigned OUT_W    = HID_W + W_W + $clog2(N_HID);
   localparam int unsigned NODE_W   = $clog2(N_NODES);
   localparam int unsigned STEP_MAX = (N_NODES > N_FEAT) ? ((N_NODES > N_HID) ? N_NODES : N_HID)
                                                         : ((N_FEAT > N_HID) ? N_FEAT : N_HID);
   localparam int unsigned STEP_W   = $clog2(STEP_MAX + 1);

   typedef enum logic [2:0] {StIdle, StAgg, StL1, StL2, StOut} state_e;

   state_e                            state_q, state_d;
   logic [NODE_W-1:0]                 node_q, node_d;
   logic [STEP_W-1:0]                 step_q, step_d;
   logic [N_NODES*N_FEAT*IN_W-1:0]    x_q, x_d;
   logic [N_NODES*N_NODES-1:0]        adj_q, adj_d;
   logic [N_FEAT*N_HID*W_W-1:0]       w1_q, w1_d;
   logic [N_HID*N_OUT*W_W-1:0]        w2_q, w2_d;
   logic [N_FEAT-1:0][AGG_W-1:0]      agg_q, agg_d;
   logic [N_HID-1:0][HID_W-1:0]       hid_q, hid_d;
   logic [N_OUT-1:0][OUT_W-1:0]       acc_q, acc_d;

   // Operands selected by the current node/step.
   logic [N_FEAT*IN_W-1:0]            x_row;
   logic [N_FEAT-1:0][AGG_W-1:0]      x_ext;
   logic                              adj_bit;
   logic [N_HID*W_W-1:0]              w1_row;
   logic [N_OUT*W_W-1:0]              w2_row;
   logic [AGG_W-1:0]                  agg_cur;
   logic [HID_W-1:0]                  hid_cur;
   logic [STEP_W-1:0]                 last_step;
   logic                              step_done;

   assign x_row   = x_q[int'(step_q)*N_FEAT*IN_W +: N_FEAT*IN_W];
   assign adj_bit = adj_q[int'(node_q)*N_NODES + int'(step_q)];
   assign w1_row  = w1_q[int'(step_q)*N_HID*W_W +: N_HID*W_W];
   assign w2_row  = w2_q[int'(step_q)*N_OUT*W_W +: N_OUT*W_W];
   assign agg_cur = agg_q[int'(step_q)];
   assign hid_cur = hid_q[int'(step_q)];

   always_comb begin
      x_ext = '0;
      for (int f = 0; f < N_FEAT; f++) x_ext[f] = AGG_W'(x_row[f*IN_W +: IN_W]);
   end

   always_comb begin
      last_step = '0;
      unique case (state_q)
         StAgg:   last_step = STEP_W'(N_NODES - 1);
         StL1:    last_step = STEP_W'(N_FEAT - 1);
         StL2:    last_step = STEP_W'(N_HID - 1);
         default: last_step = '0;
      endcase
   end
   assign step_done = (step_q == last_step);

   always_comb begin
      state_d = state_q;
      node_d  = node_q;
      step_d  = step_q;
      x_d     = x_q;
      adj_d   = adj_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      agg_d   = agg_q;
      hid_d   = hid_q;
      acc_d   = acc_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               x_d     = bus.x_flat;
               adj_d   = bus.adj;
               w1_d    = bus.w1_flat;
               w2_d    = bus.w2_flat;
               node_d  = '0;
               step_d  = '0;
               agg_d   = '0;
               state_d = StAgg;
            end
         end
         StAgg: begin
            // Starting from zero, max over unsigned values also covers the no-neighbour case.
            if (adj_bit) begin
               for (int f = 0; f < N_FEAT; f++) begin
                  if (AGG_MODE == 0) agg_d[f] = agg_q[f] + x_ext[f];
                  else if (x_ext[f] > agg_q[f]) agg_d[f] = x_ext[f];
               end
            end
            if (step_done) begin
               step_d  = '0;
               hid_d   = '0;
               state_d = StL1;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         StL1: begin
            for (int h = 0; h < N_HID; h++)
               hid_d[h] = hid_q[h] + HID_W'(agg_cur) * HID_W'(w1_row[h*W_W +: W_W]);
            if (step_done) begin
               step_d  = '0;
               acc_d   = '0;
               state_d = StL2;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         StL2: begin
            for (int o = 0; o < N_OUT; o++)
               acc_d[o] = acc_q[o] + OUT_W'(hid_cur) * OUT_W'(w2_row[o*W_W +: W_W]);
            if (step_done) begin
               step_d  = '0;
               state_d = StOut;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               if (node_q == NODE_W'(N_NODES - 1)) begin
                  node_d  = '0;
                  state_d = StIdle;
               end else begin
                  node_d  = node_q + NODE_W'(1);
                  agg_d   = '0;
                  state_d = StAgg;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         node_q  <= '0;
         step_q  <= '0;
         x_q     <= '0;
         adj_q   <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         agg_q   <= '0;
         hid_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         node_q  <= node_d;
         step_q  <= step_d;
         x_q     <= x_d;
         adj_q   <= adj_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         agg_q   <= agg_d;
         hid_q   <= hid_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle) && !rst;
   assign bus.out_valid = (state_q == StOut);
   assign bus.out_node  = node_q;
   assign bus.out_last  = (state_q == StOut) && (node_q == NODE_W'(N_NODES - 1));
   assign bus.out_data  = (state_q == StOut) ? acc_q : '0;
   assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_gnn_node_engine.sv
// Directed bench for gnn_node_engine: a sum-mode instance and a max-mode instance share stimulus.
module tb_gnn_node_engine;
   localparam int NN = 4, NF = 4, NH = 4, NO = 2, IW = 5, WW = 5, OW = 21;

   logic clk = 1'b0;
   logic rst;
   logic sel;
   logic in_valid;
   logic out_ready;
   int   checks = 0;
   int   failures = 0;

   int   xv  [NN][NF];
   int   w1v [NF][NH];
   int   w2v [NH][NO];
   logic [NN*NN-1:0] adjv;
   int   exp_y [NN][NO];

   logic [NN*NF*IW-1:0] x_flat;
   logic [NF*NH*WW-1:0] w1_flat;
   logic [NH*NO*WW-1:0] w2_flat;

   gnn_node_if if0 ();
   gnn_node_if if1 ();

   gnn_node_engine #(.AGG_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   gnn_node_engine #(.AGG_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   assign if0.in_valid  = in_valid & ~sel;
   assign if1.in_valid  = in_valid & sel;
   assign if0.x_flat    = x_flat;
   assign if1.x_flat    = x_flat;
   assign if0.adj       = adjv;
   assign if1.adj       = adjv;
   assign if0.w1_flat   = w1_flat;
   assign if1.w1_flat   = w1_flat;
   assign if0.w2_flat   = w2_flat;
   assign if1.w2_flat   = w2_flat;
   assign if0.out_ready = out_ready;
   assign if1.out_ready = out_ready;

   logic          o_valid, o_last, o_busy, o_in_ready;
   logic [1:0]    o_node;
   logic [2*OW-1:0] o_data;
   assign o_valid    = sel ? if1.out_valid : if0.out_valid;
   assign o_last     = sel ? if1.out_last  : if0.out_last;
   assign o_busy     = sel ? if1.busy      : if0.busy;
   assign o_in_ready = sel ? if1.in_ready  : if0.in_ready;
   assign o_node     = sel ? if1.out_node  : if0.out_node;
   assign o_data     = sel ? if1.out_data  : if0.out_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int n = 0; n < NN; n++)
         for (int f = 0; f < NF; f++) x_flat[(n*NF+f)*IW +: IW] = IW'(xv[n][f]);
      for (int f = 0; f < NF; f++)
         for (int h = 0; h < NH; h++) w1_flat[(f*NH+h)*WW +: WW] = WW'(w1v[f][h]);
      for (int h = 0; h < NH; h++)
         for (int o = 0; o < NO; o++) w2_flat[(h*NO+o)*WW +: WW] = WW'(w2v[h][o]);
   endtask

   task automatic fill(input int xval, input int wval);
      for (int n = 0; n < NN; n++) for (int f = 0; f < NF; f++) xv[n][f] = xval;
      for (int f = 0; f < NF; f++) for (int h = 0; h < NH; h++) w1v[f][h] = wval;
      for (int h = 0; h < NH; h++) for (int o = 0; o < NO; o++) w2v[h][o] = wval;
   endtask

   task automatic set_exp(input int n, input int y0, input int y1);
      exp_y[n][0] = y0;
      exp_y[n][1] = y1;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!o_valid && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   // Called at #1 after an edge with the selected engine idle.
   task automatic run_graph(input string tag, input int stall_node);
      int cnt;
      pack();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_busy_accept"}, o_busy, 1);
      for (int n = 0; n < NN; n++) begin
         wait_valid(cnt);
         chk($sformatf("%s_lat_n%0d", tag, n), cnt, 12);
         chk($sformatf("%s_node_n%0d", tag, n), o_node, n);
         chk($sformatf("%s_last_n%0d", tag, n), o_last, (n == NN-1));
         for (int o = 0; o < NO; o++)
            chk($sformatf("%s_y%0d_n%0d", tag, o, n), o_data[o*OW +: OW], exp_y[n][o]);
         if (n == stall_node) begin
            out_ready = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               in_valid = (i % 3 == 0);
               chk($sformatf("%s_stall_valid_%0d", tag, i), o_valid, 1);
               chk($sformatf("%s_stall_node_%0d", tag, i), o_node, n);
               chk($sformatf("%s_stall_y0_%0d", tag, i), o_data[0 +: OW], exp_y[n][0]);
               chk($sformatf("%s_stall_busy_%0d", tag, i), o_busy, 1);
               chk($sformatf("%s_stall_inrdy_%0d", tag, i), o_in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_in_ready_end"}, o_in_ready, 1);
      chk({tag, "_busy_end"}, o_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      sel = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      fill(0, 0); adjv = '0;
      pack();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready0", if0.in_ready, 0);
      chk("rst_in_ready1", if1.in_ready, 0);
      chk("rst_out_valid", if0.out_valid, 0);
      chk("rst_busy", if0.busy, 0);
      chk("rst_out_data", if0.out_data, 0);
      chk("rst_out_node", if0.out_node, 0);
      chk("rst_out_last", if0.out_last, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", if0.in_ready, 1);

      // All ones, sum mode.
      fill(1, 1); adjv = '1;
      for (int n = 0; n < NN; n++) set_exp(n, 64, 64);
      run_graph("t1", -1);

      // Maximum operands, no wrap.
      fill(31, 31); adjv = '1;
      for (int n = 0; n < NN; n++) set_exp(n, 1906624, 1906624);
      run_graph("t2", -1);

      // Identity adjacency, x[n][f] = n+1.
      fill(0, 1); adjv = 16'b1000_0100_0010_0001;
      for (int n = 0; n < NN; n++) for (int f = 0; f < NF; f++) xv[n][f] = n + 1;
      for (int n = 0; n < NN; n++) set_exp(n, 16*(n+1), 16*(n+1));
      run_graph("t3a", -1);
      adjv = 16'b1000_0000_0010_0001;
      set_exp(2, 0, 0);
      run_graph("t3b", -1);

      // Max aggregation on the second engine.
      sel = 1'b1;
      fill(0, 0); adjv = '1;
      for (int j = 0; j < NN; j++) xv[j][0] = j * 7;
      w1v[0][0] = 1; w2v[0][0] = 1;
      for (int n = 0; n < NN; n++) set_exp(n, 21, 0);
      run_graph("t4", -1);
      sel = 1'b0;

      // Output back-pressure at node 1.
      fill(1, 1); adjv = '1;
      for (int n = 0; n < NN; n++) set_exp(n, 64, 64);
      run_graph("t5", 1);

      // Reset during L1 of node 2.
      fill(31, 31); adjv = '1;
      pack();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 2; n++) begin
         wait_valid(cnt);
         chk($sformatf("t6_pre_valid_n%0d", n), o_valid, 1);
         @(posedge clk); #1;
      end
      repeat (5) @(posedge clk);
      #1;
      chk("t6_busy_before_rst", o_busy, 1);
      chk("t6_valid_before_rst", o_valid, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst_out_valid", o_valid, 0);
      chk("t6_rst_busy", o_busy, 0);
      chk("t6_rst_in_ready", o_in_ready, 0);
      chk("t6_rst_out_node", o_node, 0);
      chk("t6_rst_out_data", o_data, 0);
      rst = 1'b0;
      #1;
      chk("t6_in_ready_after", o_in_ready, 1);
      fill(0, 1); adjv = 16'b1000_0100_0010_0001;
      for (int n = 0; n < NN; n++) for (int f = 0; f < NF; f++) xv[n][f] = n + 1;
      for (int n = 0; n < NN; n++) set_exp(n, 16*(n+1), 16*(n+1));
      run_graph("t6_new", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
